// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the boot_loader block.
//   boot_state_e : loader FSM states
//   WORD_W       : instruction word width (bits)
//   LEN_W        : width of the image-length field in the stream header (bits)
// -----------------------------------------------------------------------------
package boot_pkg;

   localparam int WORD_W = 32;
   localparam int LEN_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } boot_state_e;

endpackage : boot_pkg

// File: rtl/boot_word_packer.sv
// -----------------------------------------------------------------------------
// boot_word_packer
// Collects bytes into little-endian 32-bit words. The first byte of a word
// becomes bits [7:0] and the fourth byte becomes bits [31:24].
// Ports:
//   clk        in  : system clock, rising edge
//   reset      in  : asynchronous active-high reset, clears the partial word
//   accept     in  : a byte is taken this cycle
//   rx_byte    in  : the byte being taken
//   word       out : completed word, valid while word_done is high
//   word_done  out : combinational pulse, high when the 4th byte is taken
// -----------------------------------------------------------------------------
module boot_word_packer
   import boot_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              accept,
   input  logic [7:0]        rx_byte,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   logic [1:0]        cnt_q;
   logic [WORD_W-1:0] shift_q;

   // NOTE: every register here has a defined reset value so a reset mid-load
   // leaves no stale partial word behind; sequential state uses <= only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= 2'd0;
         shift_q <= '0;
      end else if (accept) begin
         cnt_q   <= cnt_q + 2'd1;
         shift_q <= {rx_byte, shift_q[WORD_W-1:8]};
      end
   end

   // The word is presented in the same cycle as its last byte so the top can
   // register it at the accepting edge.
   assign word      = {rx_byte, shift_q[WORD_W-1:8]};
   assign word_done = accept && (cnt_q == 2'd3);

endmodule : boot_word_packer

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Receives a byte stream (LEN_LO, LEN_HI, then 4*N data bytes, LSB first per
// word) and writes the packed words to imem from address 0. Holds the core in
// reset until the image is loaded.
// Optional feature macro: BOOT_CHECKSUM_EN -- one trailing byte holding the
// mod-256 sum of all data bytes; a mismatch ends in ERROR.
// Parameters:
//   ADDR_W     : imem word-address width
//   MAX_WORDS  : largest accepted image in words (<= 2**ADDR_W)
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rx_data/valid/ready   : byte stream handshake
//   imem_we/addr/wdata    : registered one-cycle imem write
//   core_reset            : reset to riscv_core, low only in DONE
//   done, error           : terminal-state flags
// -----------------------------------------------------------------------------
module boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   boot_state_e       state_q,      state_d;
   logic [7:0]        len_lo_q,     len_lo_d;
   logic [LEN_W-1:0]  len_q,        len_d;
   logic [LEN_W-1:0]  word_cnt_q,   word_cnt_d;
   logic              imem_we_q,    imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
   logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        sum_q,        sum_d;
`endif

   logic [LEN_W-1:0]  rx_len;
   logic              all_written;
   logic              pack_accept;
   logic [WORD_W-1:0] pack_word;
   logic              pack_done;

   assign rx_len      = {rx_data, len_lo_q};
   assign all_written = (word_cnt_q == len_q);

   // Decoded straight from state (not from rx_ready) to keep the packer
   // strobe out of the next-state combinational path.
   assign pack_accept = rx_valid && (state_q == DATA) && !all_written;

   boot_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .accept    (pack_accept),
      .rx_byte   (rx_data),
      .word      (pack_word),
      .word_done (pack_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         len_lo_q     <= '0;
         len_q        <= '0;
         word_cnt_q   <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   // NOTE: every output of this block is given a default before the case so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      rx_ready     = 1'b0;

      case (state_q)
         IDLE: state_d = LEN_LO;

         LEN_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               len_lo_d = rx_data;
               state_d  = LEN_HI;
            end
         end

         LEN_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_len == '0) begin
                  state_d = DONE;
               end else if (rx_len > MAX_LEN) begin
                  state_d = ERROR;
               end else begin
                  len_d   = rx_len;
                  state_d = DATA;
               end
            end
         end

         DATA: begin
            if (all_written) begin
               // The last write strobe is on the bus this cycle; leaving DATA
               // only now makes the release land one cycle after the strobe.
               // rx_ready stays low so no byte beyond the image is consumed.
`ifdef BOOT_CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = DONE;
`endif
            end else begin
               rx_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
               if (rx_valid) begin
                  sum_d = sum_q + rx_data;
               end
`endif
               if (pack_done) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = ADDR_W'(word_cnt_q);
                  imem_wdata_d = pack_word;
                  word_cnt_d   = word_cnt_q + 1'b1;
               end
            end
         end

`ifdef BOOT_CHECKSUM_EN
         CSUM: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               state_d = (rx_data == sum_q) ? DONE : ERROR;
            end
         end
`endif

         DONE, ERROR: ;

         default: state_d = ERROR;
      endcase
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_reset = (state_q != DONE);
   assign done       = (state_q == DONE);
   assign error      = (state_q == ERROR);

endmodule : boot_loader

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Directed bench for boot_loader. Expected imem writes are queued when the
// stimulus issues the byte that completes a word; a negedge monitor pops and
// compares on every imem_we. Timing of release/done/error is checked inline.
// Honors BOOT_CHECKSUM_EN to match the build of the design.
// -----------------------------------------------------------------------------
module tb_boot_loader;

   localparam int ADDR_W = 8;

   logic              clk      = 1'b0;
   logic              reset    = 1'b0;
   logic [7:0]        rx_data  = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_reset;
   logic              done;
   logic              error;

   always #5 clk = ~clk;

   boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] img [0:3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued write.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (!reset && imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(imem_addr), 32'(e.addr));
            check("write_data", imem_wdata, e.data);
         end
      end
   end

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one byte and returns #1 after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $display("FAIL rx_ready_timeout: ready=0 after %0d cycles, expected 1", t);
      end else begin
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      check("rst_core_reset", 32'(core_reset), 1);
      check("rst_rx_ready",   32'(rx_ready),   0);
      check("rst_imem_we",    32'(imem_we),    0);
      check("rst_imem_addr",  32'(imem_addr),  0);
      check("rst_imem_wdata", imem_wdata,      0);
      check("rst_done",       32'(done),       0);
      check("rst_error",      32'(error),      0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rx_ready_first_cycle", 32'(rx_ready), 0);
      @(posedge clk);
      #1;
      check("rx_ready_second_cycle", 32'(rx_ready), 1);
   endtask

   // Loads img[0..n-1] (n >= 1), optionally with random source stalls.
   task automatic load(input int n, input bit stall_en, input bit bad_csum);
      logic [7:0] b;
`ifdef BOOT_CHECKSUM_EN
      logic [7:0] sum = 8'h00;
`endif
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = img[w][8*k +: 8];
`ifdef BOOT_CHECKSUM_EN
            sum = sum + b;
`endif
            if (k == 3) exp_q.push_back('{addr: w[ADDR_W-1:0], data: img[w]});
            if (stall_en && $urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
            send_byte(b);
         end
      end
      check("last_strobe", 32'(imem_we), 1);
      check("core_reset_during_strobe", 32'(core_reset), 1);
      check("rx_ready_during_strobe", 32'(rx_ready), 0);
`ifdef BOOT_CHECKSUM_EN
      send_byte(bad_csum ? sum + 8'h01 : sum);
`else
      @(posedge clk);
      #1;
`endif
      check("end_done",       32'(done),       32'(!bad_csum));
      check("end_error",      32'(error),      32'(bad_csum));
      check("end_core_reset", 32'(core_reset), 32'(bad_csum));
      check("end_rx_ready",   32'(rx_ready),   0);
      idle(3);
      check("pending_writes", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      img[0] = 32'h0010_0013;
      img[1] = 32'h0020_0093;
      img[2] = 32'h0;
      img[3] = 32'h0;

      // Two-word load, back to back.
      do_reset();
      load(2, 1'b0, 1'b0);

      // Same image with random stalls between bytes.
      do_reset();
      load(2, 1'b1, 1'b0);

      // Length limit: N = 0x0101 > 256.
      do_reset();
      send_byte(8'h01);
      send_byte(8'h01);
      check("len_err_error",      32'(error),      1);
      check("len_err_rx_ready",   32'(rx_ready),   0);
      check("len_err_core_reset", 32'(core_reset), 1);
      check("len_err_done",       32'(done),       0);
      idle(6);
      check("len_err_sticky",     32'(error),      1);
      check("len_err_core_hold",  32'(core_reset), 1);

      // Empty image: done one cycle after LEN_HI, no write.
      do_reset();
      send_byte(8'h00);
      send_byte(8'h00);
      check("empty_done",       32'(done),       1);
      check("empty_core_reset", 32'(core_reset), 0);
      check("empty_imem_we",    32'(imem_we),    0);
      idle(4);
      check("empty_done_hold",  32'(done),       1);

      // Reset after 6 data bytes, then reload a one-word image.
      do_reset();
      send_byte(8'h02);
      send_byte(8'h00);
      exp_q.push_back('{addr: 8'h00, data: 32'h0010_0013});
      foreach (img[i]) if (i == 0) begin
         send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      end
      send_byte(8'h93);
      send_byte(8'h00);
      reset = 1'b1;
      #1;
      check("midload_core_reset", 32'(core_reset), 1);
      check("midload_rx_ready",   32'(rx_ready),   0);
      check("midload_pending",    exp_q.size(),    0);
      do_reset();
      img[0] = 32'hDEAD_BEEF;
      load(1, 1'b0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
      // Checksum match and mismatch on a single word 0x00000013.
      img[0] = 32'h0000_0013;
      do_reset();
      load(1, 1'b0, 1'b0);
      do_reset();
      load(1, 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_boot_loader
